instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch sequencer for the Harvard core. Takes the current PC address and
//  drives the instruction-memory read port, tolerating waitrequest. Latches the word and
//  generates the single-bit 'state' strobe that tells the PC and control path when EXEC completes.
//  Sits between the instruction-memory bus and the PC/decode logic.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max consecutive waitrequest cycles before fetch_fault (>=2)
//  BYTE_SWAP       1    1: convert little-endian bus word to MIPS big-endian instruction_word
// PORTS
//  clk               in   1   system clock, all state on posedge
//  reset             in   1   synchronous, active-high
//  addr              in   32  current PC (from PC block)
//  finish            in   1   PC reports exit address 0 reached
//  exec_stall        in   1   data path not ready (e.g. dmem waitrequest); holds EXEC
//  imem_address      out  32  instruction-memory byte address
//  imem_read         out  1   read request
//  imem_waitrequest  in   1   memory not ready; request must be held
//  imem_readdata     in   32  returned word, valid when read & !waitrequest
//  instruction_word  out  32  latched instruction, stable for whole EXEC
//  state             out  1   1 = final EXEC cycle: PC and regfile commit this edge
//  active            out  1   0 once halted or faulted
//  fetch_fault       out  1   sticky: misaligned addr or bus timeout
// BEHAVIOUR
//  Reset (sync): fsm=FETCH, instruction_word=0, state=0, imem_read=0, fetch_fault=0,
//   active=1, timeout counter=0. Reset mid-transaction aborts it; no handshake is completed.
//  FSM states: FETCH, WAIT, EXEC, HALT, FAULT.
//   FETCH: if finish -> HALT, no bus request. If addr[1:0]!=0 -> FAULT.
//          Otherwise imem_read=1 and imem_address=addr.
//          !imem_waitrequest -> latch word, go to EXEC. Else go to WAIT.
//   WAIT:  imem_read=1, imem_address=addr, held unchanged.
//          !imem_waitrequest -> latch, go to EXEC, counter=0.
//          Else counter++; counter==TIMEOUT_CYCLES-1 -> FAULT.
//   EXEC:  imem_read=0. state = !exec_stall (combinational). If state -> FETCH next cycle.
//          A stall holds EXEC with instruction_word unchanged.
//   HALT:  terminal until reset; active=0, imem_read=0, state=0.
//   FAULT: terminal until reset; fetch_fault=1, active=0, imem_read=0, state=0.
//  Latency: zero-wait memory gives 2 cycles per instruction (FETCH,EXEC).
//   Each waitrequest cycle adds 1.
//  state is asserted for exactly one cycle per instruction and never outside EXEC.
//  instruction_word changes only on the handshake edge (read & !waitrequest).
//  BYTE_SWAP=1: instruction_word = {rd[7:0],rd[15:8],rd[23:16],rd[31:24]}.
//  Counter is 16-bit and saturates. It cannot wrap before the fault triggers.
//  imem_address is combinationally addr. addr is stable outside EXEC because PC updates only on state.
//  If finish and misalignment occur in the same FETCH cycle, finish wins (HALT).
// STRUCTURE
//  Shared package cpu_pkg: typedef enum logic [2:0] fetch_state_t {FETCH,WAIT,EXEC,HALT,FAULT};
//   also localparam RESET_VECTOR = 32'hBFC00000 (PC and bench use it).
//  One sub-module: byte_swap32 (pure combinational, reused by the data-memory interface).
//  FSM, timeout counter and instruction register stay in this module.
// TESTING
//  1 Reset, addr=BFC00000, waitrequest=0, readdata=0x0000E024
//    -> read=1 in cycle 1, state=1 in cycle 2, instruction_word=0x24E00000.
//  2 waitrequest high 3 cycles -> imem_address/read held constant 3 cycles,
//    latch on 4th, state exactly once after.
//  3 exec_stall high 2 cycles in EXEC -> state low 2 cycles then 1 cycle high.
//    instruction_word unchanged throughout.
//  4 addr=0x00000000 with finish=1 -> HALT: no read issued, active=0, state never asserts.
//  5 addr=BFC00002 -> FAULT next cycle, fetch_fault=1 sticky until reset, no imem_read.
//  6 waitrequest stuck high, TIMEOUT_CYCLES=8 -> fetch_fault after 8 read cycles.
//    Reset mid-WAIT returns to FETCH with read=0 that cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the Harvard core: fetch FSM encoding and reset vector.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        EXEC,
        HALT,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/byte_swap32.sv
// Little-endian bus word to big-endian word conversion; pure combinational, also used by dmem.
module byte_swap32 #(
    parameter bit ENABLE = 1'b1
) (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = ENABLE ? {din[7:0], din[15:8], din[23:16], din[31:24]} : din;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: drives the imem read port, latches the instruction and
// produces the one-cycle 'state' commit strobe at the end of EXEC.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit BYTE_SWAP      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        finish,
    input  logic        exec_stall,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    output logic [31:0] instruction_word,
    output logic        state,
    output logic        active,
    output logic        fetch_fault
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    fetch_state_t fsm;
    logic [15:0]  wait_count;
    logic [15:0]  wait_next;
    logic [31:0]  swapped_word;
    logic         aligned;

    byte_swap32 #(.ENABLE(BYTE_SWAP)) u_swap (
        .din  (imem_readdata),
        .dout (swapped_word)
    );

    // Read and commit strobes are gated by reset so an aborted transaction drops at once.
    assign aligned      = (addr[1:0] == 2'b00);
    assign imem_address = addr;
    assign imem_read    = !reset && (((fsm == FETCH) && !finish && aligned) || (fsm == WAIT));
    assign state        = !reset && (fsm == EXEC) && !exec_stall;
    assign wait_next    = (wait_count == 16'hFFFF) ? wait_count : wait_count + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm              <= FETCH;
            instruction_word <= 32'h0;
            wait_count       <= 16'h0;
            active           <= 1'b1;
            fetch_fault      <= 1'b0;
        end else begin
            case (fsm)
                FETCH: begin
                    if (finish) begin
                        fsm    <= HALT;
                        active <= 1'b0;
                    end else if (!aligned) begin
                        fsm         <= FAULT;
                        active      <= 1'b0;
                        fetch_fault <= 1'b1;
                    end else if (!imem_waitrequest) begin
                        instruction_word <= swapped_word;
                        fsm              <= EXEC;
                    end else begin
                        fsm        <= WAIT;
                        wait_count <= 16'h0;
                    end
                end
                // The FETCH cycle counts as the first waited cycle, hence the -1 compare.
                WAIT: begin
                    if (!imem_waitrequest) begin
                        instruction_word <= swapped_word;
                        fsm              <= EXEC;
                        wait_count       <= 16'h0;
                    end else if (wait_next == TIMEOUT_LAST) begin
                        fsm         <= FAULT;
                        active      <= 1'b0;
                        fetch_fault <= 1'b1;
                        wait_count  <= wait_next;
                    end else begin
                        wait_count <= wait_next;
                    end
                end
                EXEC: begin
                    if (!exec_stall) begin
                        fsm <= FETCH;
                    end
                end
                HALT: begin
                    fsm <= HALT;
                end
                FAULT: begin
                    fsm <= FAULT;
                end
                default: begin
                    fsm <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected instruction words plus per-cycle strobe checks.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = RESET_VECTOR;
    logic        finish = 1'b0;
    logic        exec_stall = 1'b0;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest = 1'b0;
    logic [31:0] imem_readdata = 32'h0;
    logic [31:0] instruction_word;
    logic        state;
    logic        active;
    logic        fetch_fault;

    logic [31:0] expQ[$];
    logic [31:0] lastWord;
    int          checks = 0;
    int          errors = 0;

    instr_fetch #(.TIMEOUT_CYCLES(8), .BYTE_SWAP(1'b1)) dut (
        .clk              (clk),
        .reset            (reset),
        .addr             (addr),
        .finish           (finish),
        .exec_stall       (exec_stall),
        .imem_address     (imem_address),
        .imem_read        (imem_read),
        .imem_waitrequest (imem_waitrequest),
        .imem_readdata    (imem_readdata),
        .instruction_word (instruction_word),
        .state            (state),
        .active           (active),
        .fetch_fault      (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swapModel(input logic [31:0] w);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic fin, input logic stall,
                                 input logic wr, input logic [31:0] rd);
        @(negedge clk);
        reset            = 1'b0;
        addr             = a;
        finish           = fin;
        exec_stall       = stall;
        imem_waitrequest = wr;
        imem_readdata    = rd;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        addr = RESET_VECTOR;
        finish = 1'b0;
        exec_stall = 1'b0;
        imem_waitrequest = 1'b0;
        #1;
        checkOutput("read_in_reset", 32'(imem_read), 32'd0);
        checkOutput("state_in_reset", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_active", 32'(active), 32'd1);
        checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
        checkOutput("rst_word", instruction_word, 32'h0);
        expQ.delete();
        lastWord = 32'h0;
    endtask

    task automatic runInstr(input logic [31:0] a, input logic [31:0] data, input int nwait, input int nstall);
        logic [31:0] exp;
        for (int c = 0; c <= nwait; c++) begin
            applyStimulus(a, 1'b0, 1'b0, c < nwait, data);
            checkOutput("read", 32'(imem_read), 32'd1);
            checkOutput("address", imem_address, a);
            checkOutput("state_fetch", 32'(state), 32'd0);
            checkOutput("hold_word", instruction_word, lastWord);
            if (c == nwait) expQ.push_back(swapModel(data));
        end
        for (int c = 0; c <= nstall; c++) begin
            applyStimulus(a, 1'b0, c < nstall, 1'b0, $urandom);
            checkOutput("read_exec", 32'(imem_read), 32'd0);
            checkOutput("state_exec", 32'(state), 32'(c == nstall));
            if (expQ.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd1, 32'd0);
            end else if (state) begin
                exp = expQ.pop_front();
                checkOutput("exec_word", instruction_word, exp);
                lastWord = exp;
            end else begin
                checkOutput("stall_word", instruction_word, expQ[0]);
            end
        end
    endtask

    initial begin
        doReset();

        // First instruction from the reset vector, zero-wait memory.
        runInstr(RESET_VECTOR, 32'h0000E024, 0, 0);
        checkOutput("tc1_word", instruction_word, 32'h24E00000);

        runInstr(RESET_VECTOR + 32'd4, 32'h12345678, 3, 0);
        runInstr(RESET_VECTOR + 32'd8, 32'hA1B2C3D4, 0, 2);
        for (int i = 0; i < 6; i++) begin
            runInstr(RESET_VECTOR + 32'(12 + 4 * i), $urandom, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)));
        end
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        // Finish at address 0 halts without a bus request.
        doReset();
        applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        checkOutput("halt_read", 32'(imem_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(RESET_VECTOR, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
            checkOutput("halt_read_after", 32'(imem_read), 32'd0);
            checkOutput("halt_state", 32'(state), 32'd0);
            checkOutput("halt_active", 32'(active), 32'd0);
            checkOutput("halt_fault", 32'(fetch_fault), 32'd0);
        end

        // Misaligned PC faults and the fault sticks.
        doReset();
        applyStimulus(RESET_VECTOR + 32'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("misalign_read", 32'(imem_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(RESET_VECTOR, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("fault_sticky", 32'(fetch_fault), 32'd1);
            checkOutput("fault_active", 32'(active), 32'd0);
            checkOutput("fault_read", 32'(imem_read), 32'd0);
            checkOutput("fault_state", 32'(state), 32'd0);
        end

        // Finish beats misalignment in the same cycle.
        doReset();
        applyStimulus(32'h2, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h2, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("prio_active", 32'(active), 32'd0);
        checkOutput("prio_fault", 32'(fetch_fault), 32'd0);

        // Waitrequest stuck high: eight read cycles then fault.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(RESET_VECTOR, 1'b0, 1'b0, 1'b1, 32'h0);
            checkOutput("timeout_read", 32'(imem_read), 32'd1);
            checkOutput("timeout_nofault", 32'(fetch_fault), 32'd0);
        end
        applyStimulus(RESET_VECTOR, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("timeout_fault", 32'(fetch_fault), 32'd1);
        checkOutput("timeout_read_off", 32'(imem_read), 32'd0);

        // Reset in the middle of WAIT aborts the transaction, then fetch resumes cleanly.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(RESET_VECTOR, 1'b0, 1'b0, 1'b1, 32'h0);
        doReset();
        runInstr(RESET_VECTOR, 32'h8FBF0010, 1, 1);
        checkOutput("post_reset_word", instruction_word, 32'h1000BF8F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
